// File: rtl/fifo_lockstep_monitor.sv
// Shadow-model lockstep monitor for NUM_CH synchronous FIFOs: per-channel pointer/flag compare, sticky syndrome, first-fault capture.
// Latency: mismatch is combinational in the current cycle and lands in the sticky error state at the next rising edge.
// Backpressure: none; the monitor only observes the FIFO enables/flags/pointers and never stalls them.
// Optional build macro FIFO_MON_RESYNC_EN: ErrClear also reloads the shadow pointers/occupancy from the DUT.
module fifo_lockstep_monitor #(
    parameter int ADDR_WIDTH    = 8,
    parameter int NUM_CH        = 4,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int CH_IDX_WIDTH  = 4
) (
    input  logic                           Clock,
    input  logic                           Reset_,
    input  logic                           Enable,
    input  logic                           ErrClear,
    input  logic [NUM_CH-1:0]              WriteEn,
    input  logic [NUM_CH-1:0]              ReadEn,
    input  logic [NUM_CH-1:0]              Empty_,
    input  logic [NUM_CH-1:0]              HalfFull_,
    input  logic [NUM_CH-1:0]              Full_,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   WritePtr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ReadPtr,
    output logic [NUM_CH-1:0]              ChError,
    output logic [NUM_CH*5-1:0]            Syndrome,
    output logic                           detected_error,
    output logic [CH_IDX_WIDTH-1:0]        FirstCh,
    output logic [4:0]                     FirstSyn,
    output logic [ERR_CNT_WIDTH-1:0]       ErrCount,
    output logic [1:0]                     MonState
);

    localparam logic [1:0] MON_IDLE   = 2'b00;
    localparam logic [1:0] MON_ACTIVE = 2'b01;
    localparam logic [1:0] MON_FAULT  = 2'b10;

    localparam int OCC_W = ADDR_WIDTH + 1;
    localparam logic [OCC_W-1:0]         OCC_FULL = OCC_W'(2**ADDR_WIDTH);
    localparam logic [OCC_W-1:0]         OCC_HALF = OCC_W'(2**(ADDR_WIDTH-1));
    localparam logic [OCC_W-1:0]         OCC_ONE  = OCC_W'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);

    // Shadow model state, one entry per channel.
    logic [ADDR_WIDTH-1:0] shWp  [NUM_CH];
    logic [ADDR_WIDTH-1:0] shRp  [NUM_CH];
    logic [OCC_W-1:0]      shOcc [NUM_CH];

    logic [NUM_CH-1:0]     doWrite;
    logic [NUM_CH-1:0]     doRead;
    logic [ADDR_WIDTH-1:0] baseWp  [NUM_CH];
    logic [ADDR_WIDTH-1:0] baseRp  [NUM_CH];
    logic [OCC_W-1:0]      baseOcc [NUM_CH];
    logic [OCC_W-1:0]      nextOcc [NUM_CH];

    logic [4:0]              mis [NUM_CH];
    logic [NUM_CH*5-1:0]     misFlat;
    logic [NUM_CH-1:0]       misAny;
    logic                    anyMis;
    logic                    newEvent;
    logic [CH_IDX_WIDTH-1:0] firstIdx;
    logic [4:0]              firstMis;
    logic                    resync;

`ifdef FIFO_MON_RESYNC_EN
    assign resync = ErrClear & ((MonState == MON_ACTIVE) | (MonState == MON_FAULT));
`else
    assign resync = 1'b0;
`endif

    assign detected_error = |ChError;

    // Compare shadow against DUT and pick the lowest-index mismatching channel.
    always_comb begin
        anyMis   = 1'b0;
        newEvent = 1'b0;
        firstIdx = '0;
        firstMis = '0;
        misFlat  = '0;
        misAny   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mis[c] = { shWp[c] != WritePtr[c*ADDR_WIDTH +: ADDR_WIDTH],
                       shRp[c] != ReadPtr[c*ADDR_WIDTH +: ADDR_WIDTH],
                       (shOcc[c] != '0) ^ Empty_[c],
                       (shOcc[c] < OCC_HALF) ^ HalfFull_[c],
                       (shOcc[c] != OCC_FULL) ^ Full_[c] };
        end
        // Walk downwards so the lowest index wins the first-fault slot.
        for (int c = NUM_CH-1; c >= 0; c--) begin
            misFlat[c*5 +: 5] = mis[c];
            misAny[c]         = |mis[c];
            if (misAny[c]) begin
                firstIdx = CH_IDX_WIDTH'(c);
                firstMis = mis[c];
            end
            if (misAny[c] && (mis[c] != Syndrome[c*5 +: 5])) begin
                newEvent = 1'b1;
            end
        end
        anyMis = |misAny;
    end

    // Next shadow state: gated by the DUT's own flags, occupancy saturates at its bounds.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            doWrite[c] = WriteEn[c] & Full_[c];
            doRead[c]  = ReadEn[c] & Empty_[c];
            if (resync) begin
                baseWp[c]  = WritePtr[c*ADDR_WIDTH +: ADDR_WIDTH];
                baseRp[c]  = ReadPtr[c*ADDR_WIDTH +: ADDR_WIDTH];
                baseOcc[c] = {1'b0, baseWp[c] - baseRp[c]};
                // Equal pointers are ambiguous; the DUT full flag decides empty vs full.
                if ((baseWp[c] == baseRp[c]) && !Full_[c]) begin
                    baseOcc[c] = OCC_FULL;
                end
            end else begin
                baseWp[c]  = shWp[c];
                baseRp[c]  = shRp[c];
                baseOcc[c] = shOcc[c];
            end
            nextOcc[c] = baseOcc[c];
            if (doWrite[c] && !doRead[c] && (baseOcc[c] != OCC_FULL)) begin
                nextOcc[c] = baseOcc[c] + OCC_ONE;
            end else if (doRead[c] && !doWrite[c] && (baseOcc[c] != '0)) begin
                nextOcc[c] = baseOcc[c] - OCC_ONE;
            end
        end
    end

    // Shadow registers track the DUT in every state, including idle.
    always_ff @(posedge Clock) begin
        if (!Reset_) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shWp[c]  <= '0;
                shRp[c]  <= '0;
                shOcc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                shWp[c]  <= baseWp[c] + ADDR_WIDTH'(doWrite[c]);
                shRp[c]  <= baseRp[c] + ADDR_WIDTH'(doRead[c]);
                shOcc[c] <= nextOcc[c];
            end
        end
    end

    // Monitor FSM with sticky error capture; ErrClear outranks a same-cycle mismatch.
    always_ff @(posedge Clock) begin
        if (!Reset_) begin
            ChError  <= '0;
            Syndrome <= '0;
            FirstCh  <= '0;
            FirstSyn <= '0;
            ErrCount <= '0;
            MonState <= MON_IDLE;
        end else begin
            case (MonState)
                MON_IDLE: begin
                    if (Enable) begin
                        MonState <= MON_ACTIVE;
                    end
                end
                MON_ACTIVE, MON_FAULT: begin
                    if (ErrClear) begin
                        ChError  <= '0;
                        Syndrome <= '0;
                        FirstCh  <= '0;
                        FirstSyn <= '0;
                        MonState <= MON_ACTIVE;
                    end else begin
                        ChError  <= ChError | misAny;
                        Syndrome <= Syndrome | misFlat;
                        if (newEvent && (ErrCount != '1)) begin
                            ErrCount <= ErrCount + ERR_ONE;
                        end
                        if ((MonState == MON_ACTIVE) && anyMis) begin
                            MonState <= MON_FAULT;
                            FirstCh  <= firstIdx;
                            FirstSyn <= firstMis;
                        end
                    end
                end
                default: MonState <= MON_IDLE;
            endcase
            if (!Enable) begin
                MonState <= MON_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_lockstep_monitor.sv
// Directed bench: the bench plays two ideal 8-deep FIFOs (with fault injection) and keeps an integer-level monitor model.
// Latency: the model is advanced on each rising edge, every DUT output is compared on the following falling edge.
// Backpressure: not applicable; inputs are driven freely from the stimulus process.
module tb_fifo_lockstep_monitor;

    localparam int AW    = 3;
    localparam int NC    = 2;
    localparam int DEPTH = 8;

    logic            Clock = 1'b0;
    logic            Reset_ = 1'b0;
    logic            Enable = 1'b0;
    logic            ErrClear = 1'b0;
    logic [NC-1:0]   WriteEn = '0;
    logic [NC-1:0]   ReadEn = '0;
    logic [NC-1:0]   Empty_, HalfFull_, Full_;
    logic [NC*AW-1:0] WritePtr, ReadPtr;
    logic [NC-1:0]   ChError;
    logic [NC*5-1:0] Syndrome;
    logic            detected_error;
    logic [3:0]      FirstCh;
    logic [4:0]      FirstSyn;
    logic [7:0]      ErrCount;
    logic [1:0]      MonState;

    int nVec  = 0;
    int nFail = 0;

    // Environment FIFOs and fault injection.
    int          bWp  [NC] = '{0, 0};
    int          bRp  [NC] = '{0, 0};
    int          bCnt [NC] = '{0, 0};
    logic [AW-1:0] wpXor   [NC];
    logic [AW-1:0] rpXor   [NC];
    logic [2:0]    flagXor [NC];
    logic          glitch0 = 1'b0;

    // Monitor model (integers, spec-level rules).
    int         mWp [NC];
    int         mRp [NC];
    int         mOcc [NC];
    logic [4:0] mSyn [NC];
    int         mFirstCh;
    logic [4:0] mFirstSyn;
    int         mCnt;
    int         mSt;
    bit         modelValid = 1'b0;

    fifo_lockstep_monitor #(
        .ADDR_WIDTH(AW), .NUM_CH(NC), .ERR_CNT_WIDTH(8), .CH_IDX_WIDTH(4)
    ) dut (
        .Clock(Clock), .Reset_(Reset_), .Enable(Enable), .ErrClear(ErrClear),
        .WriteEn(WriteEn), .ReadEn(ReadEn), .Empty_(Empty_), .HalfFull_(HalfFull_),
        .Full_(Full_), .WritePtr(WritePtr), .ReadPtr(ReadPtr), .ChError(ChError),
        .Syndrome(Syndrome), .detected_error(detected_error), .FirstCh(FirstCh),
        .FirstSyn(FirstSyn), .ErrCount(ErrCount), .MonState(MonState)
    );

    always #5 Clock = ~Clock;

    // Environment FIFO outputs, with optional corruption.
    always_comb begin
        WritePtr  = '0;
        ReadPtr   = '0;
        Empty_    = '0;
        HalfFull_ = '0;
        Full_     = '0;
        for (int c = 0; c < NC; c++) begin
            WritePtr[c*AW +: AW] = AW'(bWp[c]) ^ wpXor[c];
            ReadPtr[c*AW +: AW]  = AW'(bRp[c]) ^ rpXor[c];
            Empty_[c]    = (bCnt[c] != 0) ^ flagXor[c][2];
            HalfFull_[c] = (bCnt[c] < DEPTH/2) ^ flagXor[c][1];
            Full_[c]     = (bCnt[c] != DEPTH) ^ flagXor[c][0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Model and environment advance on the rising edge using pre-edge inputs.
    always @(posedge Clock) begin : model
        logic [4:0] m [NC];
        int first, nst, bw, br, bo, dw, dr, g;
        bit newEv, anyM, rs;
        if (!Reset_) begin
            for (int c = 0; c < NC; c++) begin
                mWp[c] = 0; mRp[c] = 0; mOcc[c] = 0; mSyn[c] = '0;
                bWp[c] <= 0; bRp[c] <= 0; bCnt[c] <= 0;
            end
            mFirstCh = 0; mFirstSyn = '0; mCnt = 0; mSt = 0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                m[c] = { mWp[c] != int'(WritePtr[c*AW +: AW]),
                         mRp[c] != int'(ReadPtr[c*AW +: AW]),
                         (mOcc[c] != 0) != Empty_[c],
                         (mOcc[c] < DEPTH/2) != HalfFull_[c],
                         (mOcc[c] != DEPTH) != Full_[c] };
            end
            nst = mSt;
            rs  = 1'b0;
            if (mSt == 0) begin
                if (Enable) nst = 1;
            end else if (ErrClear) begin
                for (int c = 0; c < NC; c++) mSyn[c] = '0;
                mFirstCh = 0; mFirstSyn = '0; nst = 1;
`ifdef FIFO_MON_RESYNC_EN
                rs = 1'b1;
`endif
            end else begin
                newEv = 1'b0; anyM = 1'b0; first = -1;
                for (int c = 0; c < NC; c++) begin
                    if (m[c] != 0) begin
                        anyM = 1'b1;
                        if (first < 0) first = c;
                        if (m[c] != mSyn[c]) newEv = 1'b1;
                    end
                    mSyn[c] = mSyn[c] | m[c];
                end
                if (newEv && mCnt < 255) mCnt++;
                if (mSt == 1 && anyM) begin
                    nst = 2; mFirstCh = first; mFirstSyn = m[first];
                end
            end
            if (!Enable) nst = 0;
            for (int c = 0; c < NC; c++) begin
                dw = int'(WriteEn[c] & Full_[c]);
                dr = int'(ReadEn[c] & Empty_[c]);
                if (rs) begin
                    bw = int'(WritePtr[c*AW +: AW]);
                    br = int'(ReadPtr[c*AW +: AW]);
                    bo = (bw - br + DEPTH) % DEPTH;
                    if (bo == 0 && !Full_[c]) bo = DEPTH;
                end else begin
                    bw = mWp[c]; br = mRp[c]; bo = mOcc[c];
                end
                mWp[c]  = (bw + dw) % DEPTH;
                mRp[c]  = (br + dr) % DEPTH;
                mOcc[c] = bo + dw - dr;
                if (mOcc[c] > DEPTH) mOcc[c] = DEPTH;
                if (mOcc[c] < 0) mOcc[c] = 0;
                g = (c == 0 && glitch0) ? 1 : 0;
                bWp[c]  <= (bWp[c] + dw) % DEPTH;
                bRp[c]  <= (bRp[c] + dr + g) % DEPTH;
                bCnt[c] <= bCnt[c] + dw - dr - g;
            end
            mSt = nst;
        end
        modelValid = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin : compare
        logic [NC-1:0]   eCh;
        logic [NC*5-1:0] eSyn;
        if (modelValid) begin
            for (int c = 0; c < NC; c++) begin
                eSyn[c*5 +: 5] = mSyn[c];
                eCh[c]         = |mSyn[c];
            end
            chk("cyc ChError", 32'(ChError), 32'(eCh));
            chk("cyc Syndrome", 32'(Syndrome), 32'(eSyn));
            chk("cyc detected_error", 32'(detected_error), 32'(|eCh));
            chk("cyc FirstCh", 32'(FirstCh), 32'(mFirstCh));
            chk("cyc FirstSyn", 32'(FirstSyn), 32'(mFirstSyn));
            chk("cyc ErrCount", 32'(ErrCount), 32'(mCnt));
            chk("cyc MonState", 32'(MonState), 32'(mSt));
        end
    end

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        for (int c = 0; c < NC; c++) begin
            wpXor[c] = '0; rpXor[c] = '0; flagXor[c] = '0;
        end
        step(2);
        chk("reset MonState", 32'(MonState), 32'd0);
        chk("reset ChError", 32'(ChError), 32'd0);
        chk("reset ErrCount", 32'(ErrCount), 32'd0);
        chk("reset FirstSyn", 32'(FirstSyn), 32'd0);

        Reset_ = 1'b1; Enable = 1'b1; step(1);
        chk("enable MonState", 32'(MonState), 32'd1);

        // Fill ch0 to full.
        WriteEn = 2'b01; step(8); WriteEn = '0; step(1);
        chk("fill env Full_", 32'(Full_[0]), 32'd0);
        chk("fill ErrCount", 32'(ErrCount), 32'd0);
        chk("fill MonState", 32'(MonState), 32'd1);
        chk("fill detected_error", 32'(detected_error), 32'd0);

        // Ch1: 10 writes and 10 reads with pointer wrap.
        WriteEn = 2'b10; step(5); ReadEn = 2'b10; step(5); WriteEn = '0; step(5); ReadEn = '0; step(1);
        chk("wrap model WP", 32'(mWp[1]), 32'd2);
        chk("wrap model RP", 32'(mRp[1]), 32'd2);
        chk("wrap DUT WP", 32'(WritePtr[5:3]), 32'd2);
        chk("wrap detected_error", 32'(detected_error), 32'd0);

        // One-cycle read-pointer fault on ch1.
        rpXor[1] = 3'b001; step(1); rpXor[1] = '0;
        chk("rp ChError", 32'(ChError), 32'b10);
        chk("rp Syndrome ch1", 32'(Syndrome[9:5]), 32'b01000);
        chk("rp FirstCh", 32'(FirstCh), 32'd1);
        chk("rp FirstSyn", 32'(FirstSyn), 32'b01000);
        chk("rp MonState", 32'(MonState), 32'd2);
        chk("rp ErrCount", 32'(ErrCount), 32'd1);

        ErrClear = 1'b1; step(1); ErrClear = 1'b0;
        chk("clr ChError", 32'(ChError), 32'd0);
        chk("clr MonState", 32'(MonState), 32'd1);

        // Same-cycle faults on both channels: lowest index is the first fault.
        flagXor[0] = 3'b010; wpXor[1] = 3'b001; step(1); flagXor[0] = '0; wpXor[1] = '0;
        chk("dual FirstCh", 32'(FirstCh), 32'd0);
        chk("dual FirstSyn", 32'(FirstSyn), 32'b00010);
        chk("dual Syndrome ch1", 32'(Syndrome[9:5]), 32'b10000);
        chk("dual Syndrome ch0", 32'(Syndrome[4:0]), 32'b00010);
        chk("dual ErrCount", 32'(ErrCount), 32'd2);

        ErrClear = 1'b1; step(1); ErrClear = 1'b0;

        // Hidden read on the ch0 environment FIFO: persistent divergence.
        glitch0 = 1'b1; step(1); glitch0 = 1'b0; step(1);
        chk("div ChError", 32'(ChError), 32'b01);
        chk("div FirstSyn", 32'(FirstSyn), 32'b01001);
        chk("div ErrCount", 32'(ErrCount), 32'd3);

        ErrClear = 1'b1; step(1); ErrClear = 1'b0;
        chk("divclr ChError", 32'(ChError), 32'd0);
        chk("divclr MonState", 32'(MonState), 32'd1);
        step(1);
`ifdef FIFO_MON_RESYNC_EN
        chk("resync ChError", 32'(ChError), 32'd0);
        chk("resync MonState", 32'(MonState), 32'd1);
        chk("resync ErrCount", 32'(ErrCount), 32'd3);
`else
        chk("reflag ChError", 32'(ChError), 32'b01);
        chk("reflag MonState", 32'(MonState), 32'd2);
        chk("reflag ErrCount", 32'(ErrCount), 32'd4);
`endif

        // Bring ErrCount to 5 while in fault.
        wpXor[1] = 3'b001; step(1); wpXor[1] = '0;
`ifdef FIFO_MON_RESYNC_EN
        rpXor[1] = 3'b001; step(1); rpXor[1] = '0;
`endif
        chk("pre-reset ErrCount", 32'(ErrCount), 32'd5);
        chk("pre-reset MonState", 32'(MonState), 32'd2);

        // Mid-operation reset for one edge.
        Reset_ = 1'b0; step(1); Reset_ = 1'b1;
        chk("mid-reset ChError", 32'(ChError), 32'd0);
        chk("mid-reset Syndrome", 32'(Syndrome), 32'd0);
        chk("mid-reset FirstCh", 32'(FirstCh), 32'd0);
        chk("mid-reset FirstSyn", 32'(FirstSyn), 32'd0);
        chk("mid-reset ErrCount", 32'(ErrCount), 32'd0);
        chk("mid-reset MonState", 32'(MonState), 32'd0);
        chk("mid-reset detected_error", 32'(detected_error), 32'd0);

        // Simultaneous write and read at occupancy 4.
        WriteEn = 2'b01; step(4); ReadEn = 2'b01; step(1); WriteEn = '0;
        chk("wr+rd model occ", 32'(mOcc[0]), 32'd4);
        chk("wr+rd env HalfFull_", 32'(HalfFull_[0]), 32'd0);
        chk("wr+rd detected_error", 32'(detected_error), 32'd0);
        step(4); ReadEn = '0; step(1);
        chk("drain model occ", 32'(mOcc[0]), 32'd0);
        chk("drain detected_error", 32'(detected_error), 32'd0);
        chk("drain MonState", 32'(MonState), 32'd1);

        Enable = 1'b0; step(1);
        chk("disable MonState", 32'(MonState), 32'd0);
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/fifo_lockstep_monitor.md
Name: fifo_lockstep_monitor

Overview:
Parametrised multi-channel shadow-model safety monitor for synchronous FIFOs. Each channel runs an independent reference model (write pointer, read pointer, occupancy, flags), driven by the DUT's enables and gating flags. Every cycle it compares the model against the DUT pointers and flags, classifies mismatches into a per-channel syndrome and latches the first fault. DUT pointers arrive on ports, so the monitor is synthesizable for in-field lockstep checking as well as simulation.

Parameters:
ADDR_WIDTH, 8, pointer width; FIFO depth = 2**ADDR_WIDTH (must be >= 2)
NUM_CH, 4, number of monitored FIFO channels (1..16)
ERR_CNT_WIDTH, 8, width of the saturating global error-event counter
CH_IDX_WIDTH, 4, width of the first-fault channel index (must satisfy 2**CH_IDX_WIDTH >= NUM_CH)

Ports:
Clock  in  1  single clock; all state updates on rising edge
Reset_  in  1  synchronous, active-low reset, sampled on rising edge of Clock
Enable  in  1  monitor enable; leaves MON_IDLE when 1
ErrClear  in  1  one-cycle pulse; clears sticky errors and first-fault capture
WriteEn  in  NUM_CH  per-channel DUT write request
ReadEn  in  NUM_CH  per-channel DUT read request
Empty_  in  NUM_CH  DUT empty flag, active-low
HalfFull_  in  NUM_CH  DUT half-full flag, active-low
Full_  in  NUM_CH  DUT full flag, active-low
WritePtr  in  NUM_CH*ADDR_WIDTH  DUT write pointers; channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
ReadPtr  in  NUM_CH*ADDR_WIDTH  DUT read pointers, same packing
ChError  out  NUM_CH  sticky per-channel error
Syndrome  out  NUM_CH*5  sticky per-channel syndrome {WP,RP,EMPTY,HALF,FULL}, channel c at [c*5 +: 5]
detected_error  out  1  OR of ChError
FirstCh  out  CH_IDX_WIDTH  channel index of the first latched fault
FirstSyn  out  5  syndrome of the first fault
ErrCount  out  ERR_CNT_WIDTH  count of cycles with at least one new mismatch, saturating
MonState  out  2  00 MON_IDLE, 01 MON_ACTIVE, 10 MON_FAULT

Behaviour:
- Reset (Reset_=0 at edge): all shadow pointers and occupancy 0; shadow flags Empty_=0, HalfFull_=1, Full_=1; all outputs 0; state MON_IDLE. Reset applied mid-operation takes effect at that edge and discards everything, including a pending fault.
- Per channel c: DoWrite = WriteEn[c] & Full_[c]; DoRead = ReadEn[c] & Empty_[c]. These use the DUT flags, matching DUT gating.
- Shadow update on each edge: WP += DoWrite and RP += DoRead, both modulo 2**ADDR_WIDTH (natural wrap from all-ones to 0). Occupancy (ADDR_WIDTH+1 bits) += DoWrite - DoRead; simultaneous DoWrite and DoRead leave it unchanged.
- Shadow flags, derived from registered occupancy: Empty_ = (occ != 0); Full_ = (occ != 2**ADDR_WIDTH); HalfFull_ = (occ < 2**(ADDR_WIDTH-1)).
- Shadow updates occur in every state except reset, so the model tracks even while in MON_IDLE.
- Compare (combinational, current cycle): mismatch vector m[c] = {WP!=, RP!=, Empty_ XOR, HalfFull_ XOR, Full_ XOR}.
- Error registration, only in MON_ACTIVE or MON_FAULT, one-cycle latency: Syndrome[c] |= m[c]; ChError[c] |= |m[c].
- ErrCount increments by 1 in any cycle where some m[c] is nonzero and does not already equal Syndrome[c]. It holds at all-ones once saturated.
- FSM:
  - MON_IDLE -> MON_ACTIVE when Enable=1.
  - MON_ACTIVE -> MON_FAULT on the first cycle any m[c] != 0. In that cycle FirstCh = lowest-index mismatching channel and FirstSyn = its m.
  - MON_FAULT holds FirstCh/FirstSyn frozen while later errors still accumulate.
  - Enable=0 in any state -> MON_IDLE next edge; sticky state is retained.
  - ErrClear=1 in MON_FAULT or MON_ACTIVE: clears ChError, Syndrome, FirstCh, FirstSyn and returns to MON_ACTIVE; ErrCount is not cleared. ErrClear takes priority over a mismatch in the same cycle.
- Overflow/underflow: a DoWrite at shadow occ=2**ADDR_WIDTH or DoRead at occ=0 cannot arise if flags agree. If it does, occupancy saturates at its bound and the flag mismatch is already reported.

Optional Feature:
FIFO_MON_RESYNC_EN. When defined, ErrClear also reloads each channel's shadow WP/RP from the DUT WritePtr/ReadPtr and sets occupancy = (WP - RP) modulo 2**ADDR_WIDTH, or 2**ADDR_WIDTH when pointers are equal and DUT Full_=0. This lets monitoring resume after a recovered fault. When not defined, ErrClear leaves the shadow state untouched, so a persistent divergence re-flags on the next cycle.

Test Plan:
- ADDR_WIDTH=3, NUM_CH=2, Enable=1; 8 writes on ch0 -> shadow Full_=0 after 8th, ErrCount=0, MonState=01, detected_error=0.
- Ch1: 10 writes then 10 reads, with WP wrapping 7->0 -> no error; ch1 DUT pointers end at 2 (10 mod 8) and match shadow.
- Force ch1 ReadPtr off by 1 for one cycle -> next edge ChError=2'b10, Syndrome ch1=5'b01000, FirstCh=1, FirstSyn=01000, MonState=10, ErrCount=1.
- Same-cycle HalfFull_ mismatch on ch0 and WP mismatch on ch1 -> FirstCh=0, FirstSyn=00010, Syndrome ch1=10000.
- ErrClear pulse while ch0 divergence persists -> without RESYNC: ChError re-asserts one cycle later. With FIFO_MON_RESYNC_EN: stays 0, MonState=01.
- Reset_=0 for one edge during MON_FAULT with ErrCount=5 -> all outputs 0, MonState=00; simultaneous write+read at occ=4 afterwards leaves occ=4.
